branch_predictor: RTL and testbench

Direct-mapped branch target buffer with 2-bit saturating direction counters. It is the other end of the branch resolution path. In IF it predicts taken/not-taken and a target for the fetch PC. In EX it consumes the resolved outcome produced by the branch logic (its taken output) and does three things: updates its table, flags mispredictions, and supplies the corrected PC to the PC mux and the pipeline flush control.

---
 rtl/branch_predictor_pkg.sv | 14 +
 rtl/bp_sat_counter.sv | 21 ++
 rtl/branch_predictor.sv | 113 +++++++++++
 tb/tb_branch_predictor.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/branch_predictor_pkg.sv
// Shared constants for the branch target buffer: counter states, default
// geometry and the fixed instruction size used for fall-through PCs.
package branch_predictor_pkg;

   localparam logic [1:0] SNT = 2'd0;
   localparam logic [1:0] WNT = 2'd1;
   localparam logic [1:0] WT  = 2'd2;
   localparam logic [1:0] ST  = 2'd3;

   localparam int DEFAULT_ENTRIES = 16;
   localparam int DEFAULT_PC_W    = 32;
   localparam int INSN_BYTES      = 4;

endpackage

// File: rtl/bp_sat_counter.sv
// 2-bit saturating direction counter: next state from current state and the
// resolved branch direction.
module bp_sat_counter
   import branch_predictor_pkg::*;
(
   input  logic [1:0] state,
   input  logic       taken,
   output logic [1:0] next_state
);

   always_comb begin
      // NOTE: default first so every path assigns next_state and no latch is inferred.
      next_state = state;
      if (taken) begin
         if (state != ST) next_state = state + 2'd1;
      end else begin
         if (state != SNT) next_state = state - 2'd1;
      end
   end

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with 2-bit direction counters: combinational prediction
// for the fetch PC, update / misprediction / redirect from the EX stage.
module branch_predictor
   import branch_predictor_pkg::*;
#(
   parameter int ENTRIES = DEFAULT_ENTRIES,
   parameter int PC_W    = DEFAULT_PC_W
) (
   input  logic            CLK,
   input  logic            RESET,
   input  logic [PC_W-1:0] PC_IF,
   output logic            PREDICT_TAKEN,
   output logic [PC_W-1:0] PREDICT_TARGET,
   input  logic            EX_VALID,
   input  logic            EX_IS_BRANCH,
   input  logic [PC_W-1:0] EX_PC,
   input  logic            EX_TAKEN,
   input  logic [PC_W-1:0] EX_TARGET,
   input  logic            EX_PRED_TAKEN,
   input  logic [PC_W-1:0] EX_PRED_TARGET,
   output logic            MISPREDICT,
   output logic [PC_W-1:0] CORRECT_PC,
   output logic [31:0]     BRANCH_COUNT,
   output logic [31:0]     MISPREDICT_COUNT
);

   localparam int IDX   = $clog2(ENTRIES);
   localparam int TAG_W = PC_W - IDX - 2;
   localparam logic [PC_W-1:0] PC_STEP = PC_W'(INSN_BYTES);

   logic             valid_q  [ENTRIES];
   logic [TAG_W-1:0] tag_q    [ENTRIES];
   logic [PC_W-1:0]  target_q [ENTRIES];
   logic [1:0]       ctr_q    [ENTRIES];

   logic [31:0] branch_count_q, mispredict_count_q;

   logic [IDX-1:0]   if_idx, ex_idx;
   logic [TAG_W-1:0] if_tag, ex_tag;
   logic             if_hit, ex_hit, upd, stale;
   logic [PC_W-1:0]  ex_seq;
   logic [1:0]       ctr_next;

   // Byte-offset bits carry no information for a 4-byte-aligned fetch stream.
   logic unused_pc_bits;
   assign unused_pc_bits = ^{PC_IF[1:0], EX_PC[1:0]};

   assign if_idx = PC_IF[IDX+1:2];
   assign if_tag = PC_IF[PC_W-1:IDX+2];
   assign ex_idx = EX_PC[IDX+1:2];
   assign ex_tag = EX_PC[PC_W-1:IDX+2];

   assign if_hit         = valid_q[if_idx] && (tag_q[if_idx] == if_tag);
   assign PREDICT_TAKEN  = if_hit && ctr_q[if_idx][1];
   assign PREDICT_TARGET = PREDICT_TAKEN ? target_q[if_idx] : PC_IF + PC_STEP;

   assign ex_hit = valid_q[ex_idx] && (tag_q[ex_idx] == ex_tag);
   assign upd    = EX_VALID && EX_IS_BRANCH;
   assign stale  = EX_VALID && !EX_IS_BRANCH && EX_PRED_TAKEN;
   assign ex_seq = EX_PC + PC_STEP;

   assign MISPREDICT = stale ||
                       (upd && ((EX_TAKEN != EX_PRED_TAKEN) ||
                                (EX_TAKEN && (EX_PRED_TARGET != EX_TARGET))));
   assign CORRECT_PC = (upd && EX_TAKEN) ? EX_TARGET : ex_seq;

   bp_sat_counter u_sat_counter (
      .state      (ctr_q[ex_idx]),
      .taken      (EX_TAKEN),
      .next_state (ctr_next)
   );

   // NOTE: the table is plain flops, not RAM, precisely so the async reset can clear every entry.
   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         for (int i = 0; i < ENTRIES; i++) begin
            valid_q[i]  <= 1'b0;
            tag_q[i]    <= '0;
            target_q[i] <= '0;
            ctr_q[i]    <= WNT;
         end
      end else if (upd) begin
         if (ex_hit) begin
            ctr_q[ex_idx] <= ctr_next;
            if (EX_TAKEN) target_q[ex_idx] <= EX_TARGET;
         end else if (EX_TAKEN) begin
            valid_q[ex_idx]  <= 1'b1;
            tag_q[ex_idx]    <= ex_tag;
            target_q[ex_idx] <= EX_TARGET;
            ctr_q[ex_idx]    <= WT;
         end
      end else if (stale && ex_hit) begin
         valid_q[ex_idx] <= 1'b0;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so all flops sample pre-edge values.
   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         branch_count_q     <= '0;
         mispredict_count_q <= '0;
      end else begin
         if (upd && (branch_count_q != '1))
            branch_count_q <= branch_count_q + 32'd1;
         if (MISPREDICT && (mispredict_count_q != '1))
            mispredict_count_q <= mispredict_count_q + 32'd1;
      end
   end

   assign BRANCH_COUNT     = branch_count_q;
   assign MISPREDICT_COUNT = mispredict_count_q;

endmodule

// File: tb/tb_branch_predictor.sv
// Self-checking bench for branch_predictor: a table of EX/IF vectors with
// hand-derived expectations, scored through a queue, plus reset corner cases.
module tb_branch_predictor;

   logic        CLK = 1'b0;
   logic        RESET;
   logic [31:0] PC_IF;
   logic        PREDICT_TAKEN;
   logic [31:0] PREDICT_TARGET;
   logic        EX_VALID, EX_IS_BRANCH, EX_TAKEN, EX_PRED_TAKEN;
   logic [31:0] EX_PC, EX_TARGET, EX_PRED_TARGET;
   logic        MISPREDICT;
   logic [31:0] CORRECT_PC, BRANCH_COUNT, MISPREDICT_COUNT;

   branch_predictor #(.ENTRIES(16), .PC_W(32)) dut (
      .CLK(CLK), .RESET(RESET), .PC_IF(PC_IF),
      .PREDICT_TAKEN(PREDICT_TAKEN), .PREDICT_TARGET(PREDICT_TARGET),
      .EX_VALID(EX_VALID), .EX_IS_BRANCH(EX_IS_BRANCH), .EX_PC(EX_PC),
      .EX_TAKEN(EX_TAKEN), .EX_TARGET(EX_TARGET),
      .EX_PRED_TAKEN(EX_PRED_TAKEN), .EX_PRED_TARGET(EX_PRED_TARGET),
      .MISPREDICT(MISPREDICT), .CORRECT_PC(CORRECT_PC),
      .BRANCH_COUNT(BRANCH_COUNT), .MISPREDICT_COUNT(MISPREDICT_COUNT)
   );

   always #5 CLK = ~CLK;

   typedef struct {
      logic        ex_valid;
      logic        ex_br;
      logic [31:0] ex_pc;
      logic        ex_taken;
      logic [31:0] ex_target;
      logic        ex_pt;
      logic [31:0] ex_ptgt;
      logic [31:0] pc_if;
      logic        exp_mis;
      logic [31:0] exp_cpc;
      logic        exp_pt;
      logic [31:0] exp_ptgt;
   } vec_t;

   typedef struct {
      logic        mis;
      logic [31:0] cpc;
      logic        pt;
      logic [31:0] ptgt;
   } exp_t;

   vec_t vecs[$];
   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;
   logic [31:0] exp_bc = 0;
   logic [31:0] exp_mc = 0;

   function automatic vec_t mk(input logic v, input logic br, input logic [31:0] pc,
                               input logic tk, input logic [31:0] tgt, input logic pt,
                               input logic [31:0] ptgt, input logic [31:0] pcif,
                               input logic emis, input logic [31:0] ecpc,
                               input logic ept, input logic [31:0] eptgt);
      vec_t r;
      r.ex_valid = v;   r.ex_br = br;     r.ex_pc = pc;      r.ex_taken = tk;
      r.ex_target = tgt; r.ex_pt = pt;    r.ex_ptgt = ptgt;  r.pc_if = pcif;
      r.exp_mis = emis; r.exp_cpc = ecpc; r.exp_pt = ept;    r.exp_ptgt = eptgt;
      return r;
   endfunction

   function automatic vec_t idle(input logic [31:0] pcif, input logic ept,
                                 input logic [31:0] eptgt);
      return mk(0, 0, 0, 0, 0, 0, 0, pcif, 0, 0, ept, eptgt);
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   // Called at posedge+1: drive, score combinational outputs at negedge, then
   // check the performance counters after the updating edge.
   task automatic step(input vec_t v);
      exp_t e;
      EX_VALID = v.ex_valid; EX_IS_BRANCH = v.ex_br; EX_PC = v.ex_pc;
      EX_TAKEN = v.ex_taken; EX_TARGET = v.ex_target;
      EX_PRED_TAKEN = v.ex_pt; EX_PRED_TARGET = v.ex_ptgt; PC_IF = v.pc_if;
      e.mis = v.exp_mis; e.cpc = v.exp_cpc; e.pt = v.exp_pt; e.ptgt = v.exp_ptgt;
      sb.push_back(e);
      if (v.ex_valid && v.ex_br) exp_bc++;
      if (v.exp_mis) exp_mc++;
      @(negedge CLK);
      e = sb.pop_front();
      check("predict_taken", {31'd0, PREDICT_TAKEN}, {31'd0, e.pt});
      check("predict_target", PREDICT_TARGET, e.ptgt);
      check("mispredict", {31'd0, MISPREDICT}, {31'd0, e.mis});
      if (e.mis) check("correct_pc", CORRECT_PC, e.cpc);
      @(posedge CLK);
      #1;
      check("branch_count", BRANCH_COUNT, exp_bc);
      check("mispredict_count", MISPREDICT_COUNT, exp_mc);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      RESET = 1'b0;
      vecs.push_back(idle(32'h100, 0, 32'h104));
      // cold taken branch, then warm-up
      vecs.push_back(mk(1,1,32'h100,1,32'h80,0,32'h104, 32'h100, 1,32'h80, 0,32'h104));
      vecs.push_back(idle(32'h100, 1, 32'h80));
      // three more taken: WT -> ST, saturate
      for (int i = 0; i < 3; i++)
         vecs.push_back(mk(1,1,32'h100,1,32'h80,1,32'h80, 32'h100, 0,0, 1,32'h80));
      // ST -> WT (still taken), WT -> WNT
      vecs.push_back(mk(1,1,32'h100,0,32'h80,1,32'h80, 32'h100, 1,32'h104, 1,32'h80));
      vecs.push_back(mk(1,1,32'h100,0,32'h80,1,32'h80, 32'h100, 1,32'h104, 1,32'h80));
      vecs.push_back(idle(32'h100, 0, 32'h104));
      // back to WT, then target change 0x80 -> 0x200
      vecs.push_back(mk(1,1,32'h100,1,32'h80,0,32'h104, 32'h100, 1,32'h80, 0,32'h104));
      vecs.push_back(mk(1,1,32'h100,1,32'h200,1,32'h80, 32'h100, 1,32'h200, 1,32'h80));
      vecs.push_back(idle(32'h100, 1, 32'h200));
      // alias 0x140 evicts 0x100
      vecs.push_back(mk(1,1,32'h140,1,32'h300,0,32'h144, 32'h140, 1,32'h300, 0,32'h144));
      vecs.push_back(idle(32'h100, 0, 32'h104));
      // stale prediction on non-branch at 0x140
      vecs.push_back(mk(1,0,32'h140,0,0,1,32'h300, 32'h140, 1,32'h144, 1,32'h300));
      vecs.push_back(idle(32'h140, 0, 32'h144));
      // reallocate 0x100, then stale non-branch at 0x100
      vecs.push_back(mk(1,1,32'h100,1,32'h80,0,32'h104, 32'h100, 1,32'h80, 0,32'h104));
      vecs.push_back(mk(1,0,32'h100,0,0,1,32'h80, 32'h100, 1,32'h104, 1,32'h80));
      vecs.push_back(idle(32'h100, 0, 32'h104));
      // non-branch without prediction, and an invalid EX slot: no effect
      vecs.push_back(mk(1,0,32'h100,0,0,0,32'h104, 32'h100, 0,0, 0,32'h104));
      vecs.push_back(mk(0,1,32'h100,1,32'h80,0,32'h104, 32'h100, 0,0, 0,32'h104));
      vecs.push_back(idle(32'h100, 0, 32'h104));
      // fall-through wraps modulo 2^32
      vecs.push_back(idle(32'hFFFF_FFFC, 0, 32'h0));

      EX_VALID = 0; EX_IS_BRANCH = 0; EX_PC = 0; EX_TAKEN = 0; EX_TARGET = 0;
      EX_PRED_TAKEN = 0; EX_PRED_TARGET = 0; PC_IF = 32'h100;
      repeat (2) @(negedge CLK);
      check("reset_predict_taken", {31'd0, PREDICT_TAKEN}, 32'd0);
      check("reset_predict_target", PREDICT_TARGET, 32'h104);
      check("reset_mispredict", {31'd0, MISPREDICT}, 32'd0);
      check("reset_branch_count", BRANCH_COUNT, 32'd0);
      check("reset_mispredict_count", MISPREDICT_COUNT, 32'd0);
      RESET = 1'b1;
      @(posedge CLK);
      #1;

      foreach (vecs[i]) step(vecs[i]);

      // same-cycle write and lookup of index 0: lookup sees the old target
      step(mk(1,1,32'h100,1,32'h80,0,32'h104, 32'h100, 1,32'h80, 0,32'h104));
      step(mk(1,1,32'h100,1,32'h400,1,32'h80, 32'h100, 1,32'h400, 1,32'h80));
      step(idle(32'h100, 1, 32'h400));

      // asynchronous reset between edges clears predictions and counters at once
      #2;
      RESET = 1'b0;
      #1;
      check("async_predict_taken", {31'd0, PREDICT_TAKEN}, 32'd0);
      check("async_predict_target", PREDICT_TARGET, 32'h104);
      check("async_branch_count", BRANCH_COUNT, 32'd0);
      check("async_mispredict_count", MISPREDICT_COUNT, 32'd0);
      @(negedge CLK);
      RESET = 1'b1;
      @(posedge CLK);
      #1;
      exp_bc = 0;
      exp_mc = 0;
      step(idle(32'h100, 0, 32'h104));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
